// File: rtl/seq_div_pkg.sv
// ---------------------------------------------------------------------------
// seq_div_pkg
// Shared types and default widths for the sequential 8-by-4 divider.
//   DVD_W   : dividend / quotient width
//   DVS_W   : divisor / remainder width
//   state_t : divider control FSM states
// ---------------------------------------------------------------------------
package seq_div_pkg;

    localparam int DVD_W = 8;
    localparam int DVS_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

endpackage : seq_div_pkg

// File: rtl/div_step.sv
// ---------------------------------------------------------------------------
// div_step
// Combinational compare/subtract for one restoring-division step.
// Computes a_i - b_i as a_i + ~b_i + 1 on a ripple chain of fa cells.
//   a_i    : shifted partial remainder (W bits)
//   b_i    : zero-extended divisor (W bits)
//   diff_o : a_i - b_i (valid when ge_o is set)
//   ge_o   : no-borrow, i.e. a_i >= b_i
// ---------------------------------------------------------------------------
module div_step #(
    parameter int W = 5
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] diff_o,
    output logic         ge_o
);

    logic [W:0] carry;

    // Carry-in of 1 completes the two's-complement negation of b_i.
    assign carry[0] = 1'b1;

    for (genvar i = 0; i < W; i++) begin : g_bit
        fa u_fa (
            .a_i  (a_i[i]),
            .b_i  (~b_i[i]),
            .ci_i (carry[i]),
            .s_o  (diff_o[i]),
            .co_o (carry[i+1])
        );
    end

    // Carry out of an a + ~b + 1 subtraction is the no-borrow flag.
    assign ge_o = carry[W];

endmodule : div_step

// File: rtl/fa.sv
// ---------------------------------------------------------------------------
// fa
// One-bit full adder cell.
//   a_i, b_i : operand bits
//   ci_i     : carry in
//   s_o      : sum bit
//   co_o     : carry out
// ---------------------------------------------------------------------------
module fa (
    input  logic a_i,
    input  logic b_i,
    input  logic ci_i,
    output logic s_o,
    output logic co_o
);

    assign s_o  = a_i ^ b_i ^ ci_i;
    assign co_o = (a_i & b_i) | (a_i & ci_i) | (b_i & ci_i);

endmodule : fa

// File: rtl/seq_divider_8by4.sv
// ---------------------------------------------------------------------------
// seq_divider_8by4
// Sequential unsigned restoring divider, one quotient bit per clock.
//   clk         : rising-edge clock
//   rst_n       : asynchronous active-low reset
//   start       : request a division (sampled only in IDLE)
//   dividend    : DVD_W-bit unsigned dividend, sampled with start
//   divisor     : DVS_W-bit unsigned divisor, sampled with start
//   quotient    : registered quotient
//   remainder   : registered remainder
//   busy        : high while in RUN or FINISH
//   done        : one-cycle pulse when results update
//   div_by_zero : set with done for a zero divisor, held until next start
// ---------------------------------------------------------------------------
module seq_divider_8by4
    import seq_div_pkg::*;
#(
    parameter int DVD_W = seq_div_pkg::DVD_W,
    parameter int DVS_W = seq_div_pkg::DVS_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [DVD_W-1:0] dividend,
    input  logic [DVS_W-1:0] divisor,
    output logic [DVD_W-1:0] quotient,
    output logic [DVS_W-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(DVD_W + 1);
    // One extra bit keeps the shifted partial remainder from overflowing.
    localparam int PW    = DVS_W + 1;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DVD_W-1:0] dvd_q, dvd_d;
    logic [DVS_W-1:0] dvs_q, dvs_d;
    logic [PW-1:0]    part_q, part_d;
    logic [DVD_W-1:0] quo_q, quo_d;
    logic [DVD_W-1:0] quotient_q, quotient_d;
    logic [DVS_W-1:0] remainder_q, remainder_d;
    logic             done_q, done_d;
    logic             dvz_q, dvz_d;

    logic [PW-1:0]    shifted;
    logic [PW-1:0]    diff;
    logic             ge;

    // Partial remainder is always < divisor after a step, so its top bit is
    // zero and dropping it on the shift loses nothing.
    assign shifted = {part_q[DVS_W-1:0], dvd_q[DVD_W-1]};

    div_step #(
        .W (PW)
    ) u_step (
        .a_i    (shifted),
        .b_i    ({1'b0, dvs_q}),
        .diff_o (diff),
        .ge_o   (ge)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dvd_d       = dvd_q;
        dvs_d       = dvs_q;
        part_d      = part_q;
        quo_d       = quo_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        done_d      = 1'b0;
        dvz_d       = dvz_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    dvd_d  = dividend;
                    dvs_d  = divisor;
                    part_d = '0;
                    cnt_d  = '0;
                    dvz_d  = 1'b0;
                    if (divisor == '0) begin
                        // Divide-by-zero skips the iterations entirely.
                        quo_d   = '1;
                        state_d = FINISH;
                    end else begin
                        quo_d   = '0;
                        state_d = RUN;
                    end
                end
            end

            RUN: begin
                part_d = ge ? diff : shifted;
                quo_d  = {quo_q[DVD_W-2:0], ge};
                dvd_d  = dvd_q << 1;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(DVD_W - 1)) begin
                    state_d = FINISH;
                end
            end

            FINISH: begin
                quotient_d  = quo_q;
                remainder_d = part_q[DVS_W-1:0];
                done_d      = 1'b1;
                dvz_d       = (dvs_q == '0);
                state_d     = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            dvd_q       <= '0;
            dvs_q       <= '0;
            part_q      <= '0;
            quo_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            done_q      <= 1'b0;
            dvz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dvd_q       <= dvd_d;
            dvs_q       <= dvs_d;
            part_q      <= part_d;
            quo_q       <= quo_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            done_q      <= done_d;
            dvz_q       <= dvz_d;
        end
    end

    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign done        = done_q;
    assign div_by_zero = dvz_q;
    assign busy        = (state_q == RUN) || (state_q == FINISH);

endmodule : seq_divider_8by4

// File: doc/seq_divider_8by4.md
SEQ_DIVIDER_8BY4 -- requirements
Module: seq_divider_8by4

Interface
REQ-001 SHALL have parameter DVD_W, default 8, dividend and quotient width.
REQ-002 SHALL have parameter DVS_W, default 4, divisor and remainder width.
REQ-003 SHALL have one clock and an asynchronous, active-low reset: clk and rst_n.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 start  input  1  request a division; sampled only in IDLE.
REQ-007 dividend  input  DVD_W  unsigned dividend; sampled with start.
REQ-008 divisor  input  DVS_W  unsigned divisor; sampled with start.
REQ-009 quotient  output  DVD_W  unsigned quotient; registered.
REQ-010 remainder  output  DVS_W  unsigned remainder; registered.
REQ-011 busy  output  1  high while an operation is in progress.
REQ-012 done  output  1  one-cycle pulse when results become valid.
REQ-013 div_by_zero  output  1  set with done when the sampled divisor was 0; held until the next accepted start.

Function
REQ-014 SHALL implement an FSM with states IDLE, RUN, FINISH.
REQ-015 IDLE with start=1 at edge T: latch operands, clear the iteration counter, clear div_by_zero, go to RUN; with a zero divisor, go to FINISH instead.
REQ-016 RUN: one restoring-division step per cycle for exactly DVD_W cycles (T+1..T+DVD_W), then go to FINISH.
REQ-017 Step: shift the (DVS_W+1)-bit partial remainder left, inserting the dividend MSB; if partial >= divisor, subtract and shift quotient bit 1, else shift quotient bit 0.
REQ-018 The partial remainder SHALL be DVS_W+1 bits wide so no step overflows; the counter SHALL be $clog2(DVD_W+1) bits.
REQ-019 FINISH: drive quotient/remainder from the working registers, assert done for one cycle, return to IDLE unconditionally.
REQ-020 Normal latency: start sampled at edge T -> done high in the cycle after edge T+DVD_W+1 (9 cycles at defaults).
REQ-021 Divide-by-zero latency: done in the cycle after edge T+1, with quotient = all ones, remainder = 0, div_by_zero = 1.
REQ-022 busy SHALL be high exactly while the state is RUN or FINISH.
REQ-023 start in RUN or FINISH SHALL be ignored, with no effect on operands or results.
REQ-024 quotient, remainder and div_by_zero SHALL hold their last values until the next FINISH or reset.
REQ-025 Operand inputs changing after acceptance SHALL NOT affect the running operation.

Reset
REQ-026 rst_n low SHALL immediately force: state IDLE, quotient 0, remainder 0, busy 0, done 0, div_by_zero 0, counter 0, working registers 0.
REQ-027 Reset during RUN SHALL abort the operation; no done pulse follows reset release.
REQ-028 The first start after reset release SHALL be accepted normally at the first rising edge with rst_n high.

Structure
REQ-029 Package seq_div_pkg SHALL hold the FSM state typedef (IDLE, RUN, FINISH) and the default widths DVD_W and DVS_W.
REQ-030 The compare/subtract step SHALL be a combinational sub-module div_step, a (DVS_W+1)-bit ripple subtractor built from the existing fa cell, outputting difference and no-borrow (ge).
REQ-031 All FSM, counter and output registers SHALL reside in seq_divider_8by4; div_step SHALL contain no state.

Verification
REQ-032 dividend=70, divisor=10 -> after 9 cycles done=1, quotient=7, remainder=0, div_by_zero=0.
REQ-033 dividend=200, divisor=3 -> quotient=66, remainder=2; dividend=255, divisor=1 -> quotient=255, remainder=0.
REQ-034 dividend=135, divisor=0 -> done two cycles after start, quotient=8'hFF, remainder=0, div_by_zero=1, busy high for one cycle only.
REQ-035 dividend=225, divisor=15, then start re-pulsed with 9/4 during RUN -> quotient=15, remainder=0; second request ignored, exactly one done.
REQ-036 rst_n asserted at RUN cycle 4 of 100/7 -> all outputs 0 immediately, no done; a new 100/7 after release -> quotient=14, remainder=2.
REQ-037 Exhaustive sweep of all 256x15 nonzero-divisor pairs -> quotient*divisor+remainder == dividend and remainder < divisor for every pair.
